// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: length codes, FSM states
// and the lane byte-enable helper.
package mem_defs;

    localparam logic [1:0] LEN_B   = 2'b00;
    localparam logic [1:0] LEN_H   = 2'b01;
    localparam logic [1:0] LEN_BAD = 2'b10;
    localparam logic [1:0] LEN_W   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] lane);
        case (len)
            LEN_B:   return 4'b0001 << lane;
            LEN_H:   return 4'b0011 << lane;
            LEN_W:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-access handshake between the memory-access stage (master) and the
// memory responder (slave); requests are level-held until acknowledged.
interface data_mem_responder_if #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32
) ();
    logic               re;
    logic               we;
    logic [1:0]         rlen;
    logic [1:0]         wlen;
    logic [MADDR_L-1:0] raddr;
    logic [MADDR_L-1:0] waddr;
    logic [DATA_L-1:0]  wdata;
    logic [DATA_L-1:0]  rdata;
    logic               rack;
    logic               wack;
    logic               err;
    logic               busy;

    modport master (
        output re, we, rlen, wlen, raddr, waddr, wdata,
        input  rdata, rack, wack, err, busy
    );

    modport slave (
        input  re, we, rlen, wlen, raddr, waddr, wdata,
        output rdata, rack, wack, err, busy
    );
endinterface

// File: rtl/data_mem_responder_byte_ram.sv
// Word-organised RAM with four byte lanes: synchronous byte-enabled write,
// registered one-cycle read, contents never reset.
module byte_ram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [3:0]            be_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: one request at a time, ack LATENCY+2 edges after accept;
// requests stay held by the requester, so back-pressure is simply a late ack.
module data_mem_responder
    import mem_defs::*;
#(
    parameter int MADDR_L    = 32,
    parameter int DATA_L     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_rd_q;
    logic [MADDR_L-1:0] addr_q;
    logic [1:0]         len_q;
    logic [DATA_L-1:0]  wdata_q;
    logic [DATA_L-1:0]  rdata_q, rdata_d;
    logic               r_armed_q, r_armed_d;
    logic               w_armed_q, w_armed_d;
    logic               accept_rd, accept_wr;
    logic               legal;
    logic [1:0]         lane;
    logic [DATA_L-1:0]  ram_rdata, rd_shift, rd_res;

    assign lane = addr_q[1:0];

    // Legality is evaluated on the latched request, so input changes after accept cannot affect it.
    always_comb begin
        legal = 1'b1;
        if (len_q == LEN_BAD)                        legal = 1'b0;
        if (len_q == LEN_H && addr_q[0])             legal = 1'b0;
        if (len_q == LEN_W && lane != 2'b00)         legal = 1'b0;
        if ((addr_q >> (DEPTH_LOG2 + 2)) != '0)      legal = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.re && r_armed_q) begin
                    accept_rd = 1'b1;
                end else if (bus.we && w_armed_q) begin
                    accept_wr = 1'b1;
                end
                if (accept_rd || accept_wr) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ACCESS;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ACCESS: state_d = ST_ACK;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A port re-arms only once its request input has been seen low.
    always_comb begin
        r_armed_d = accept_rd ? 1'b0 : (!bus.re ? 1'b1 : r_armed_q);
        w_armed_d = accept_wr ? 1'b0 : (!bus.we ? 1'b1 : w_armed_q);
    end

    always_comb begin
        rd_shift = ram_rdata >> {lane, 3'b000};
        rd_res   = '0;
        case (len_q)
            LEN_B:   rd_res[7:0]  = rd_shift[7:0];
            LEN_H:   rd_res[15:0] = rd_shift[15:0];
            default: rd_res       = rd_shift;
        endcase
        rdata_d = rdata_q;
        if (state_q == ST_ACCESS && op_rd_q) begin
            rdata_d = legal ? rd_res : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_rd_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= LEN_B;
            wdata_q   <= '0;
            rdata_q   <= '0;
            r_armed_q <= 1'b1;
            w_armed_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            r_armed_q <= r_armed_d;
            w_armed_q <= w_armed_d;
            if (accept_rd || accept_wr) begin
                op_rd_q <= accept_rd;
                addr_q  <= accept_rd ? bus.raddr : bus.waddr;
                len_q   <= accept_rd ? bus.rlen : bus.wlen;
                wdata_q <= bus.wdata;
            end
        end
    end

    // Read is launched on the last WAIT edge so the word is ready while in ACCESS.
    byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .wr_en_i (state_q == ST_ACCESS && !op_rd_q && legal),
        .be_i    (byte_en(len_q, lane)),
        .rd_en_i (state_q == ST_WAIT && cnt_q == '0 && op_rd_q),
        .addr_i  (addr_q[DEPTH_LOG2+1:2]),
        .wdata_i (wdata_q << {lane, 3'b000}),
        .rdata_o (ram_rdata)
    );

    assign bus.rdata = rdata_q;
    assign bus.rack  = (state_q == ST_ACK) && op_rd_q;
    assign bus.wack  = (state_q == ST_ACK) && !op_rd_q;
    assign bus.err   = (state_q == ST_ACK) && !legal;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
    localparam int L   = 2;
    localparam int DL2 = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.MADDR_L(32), .DATA_L(32)) dif ();

    data_mem_responder #(
        .MADDR_L(32), .DATA_L(32), .DEPTH_LOG2(DL2), .LATENCY(L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mm [0:16383];
    int          cyc = 0;
    bit          m_valid = 0;
    int          m_acc, m_ack;
    bit          m_rd, m_err;
    logic [1:0]  m_len;
    logic [31:0] m_addr, m_wd;
    logic [31:0] m_rdata = '0;
    bit          r_arm = 1, w_arm = 1;

    function automatic bit is_legal(input logic [1:0] len, input logic [31:0] a);
        if (len == 2'b10) return 0;
        if (len == 2'b01 && a[0]) return 0;
        if (len == 2'b11 && a[1:0] != 2'b00) return 0;
        if (a >= 32'(1 << (DL2 + 2))) return 0;
        return 1;
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        bit idle, acc_r, acc_w;
        cyc++;
        if (rst) begin
            m_valid = 0; m_err = 0; m_rdata = '0; r_arm = 1; w_arm = 1;
        end else begin
            if (m_valid && cyc == m_ack) begin
                m_err = !is_legal(m_len, m_addr);
                if (m_rd) begin
                    m_rdata = '0;
                    if (!m_err)
                        for (int i = 0; i < nbytes(m_len); i++) m_rdata[8*i +: 8] = mm[int'(m_addr) + i];
                end else if (!m_err) begin
                    for (int i = 0; i < nbytes(m_len); i++) mm[int'(m_addr) + i] = m_wd[8*i +: 8];
                end
            end
            idle  = !m_valid || cyc >= m_ack + 2;
            acc_r = idle && dif.re && r_arm;
            acc_w = idle && !acc_r && dif.we && w_arm;
            if (acc_r || acc_w) begin
                m_valid = 1; m_acc = cyc; m_ack = cyc + L + 2; m_rd = acc_r;
                m_addr  = acc_r ? dif.raddr : dif.waddr;
                m_len   = acc_r ? dif.rlen : dif.wlen;
                m_wd    = dif.wdata;
            end
            r_arm = acc_r ? 0 : (!dif.re ? 1 : r_arm);
            w_arm = acc_w ? 0 : (!dif.we ? 1 : w_arm);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit at_ack, bsy;
        if (!rst && cyc > 0) begin
            at_ack = m_valid && cyc == m_ack;
            bsy    = m_valid && cyc >= m_acc && cyc <= m_ack;
            chk("rack",  32'(dif.rack), 32'(at_ack && m_rd));
            chk("wack",  32'(dif.wack), 32'(at_ack && !m_rd));
            chk("err",   32'(dif.err),  32'(at_ack && m_err));
            chk("busy",  32'(dif.busy), 32'(bsy));
            chk("rdata", dif.rdata, m_rdata);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_req(input bit rd, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rv, output bit ev,
                          output int lat);
        bit got;
        @(negedge clk);
        if (rd) begin dif.re = 1; dif.rlen = len; dif.raddr = a; end
        else    begin dif.we = 1; dif.wlen = len; dif.waddr = a; dif.wdata = wd; end
        got = 0; rv = '0; ev = 0; lat = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            lat = n;
            if (n == 1) begin
                if (rd) begin dif.raddr = $urandom; dif.rlen = 2'($urandom); end
                else    begin dif.waddr = $urandom; dif.wlen = 2'($urandom); dif.wdata = $urandom; end
            end
            if (rd ? dif.rack : dif.wack) got = 1;
        end
        if (!got) chk("ack_timeout", 32'(0), 32'(1));
        rv = dif.rdata; ev = dif.err;
        if (rd) dif.re = 0; else dif.we = 0;
    endtask

    task automatic wait_sig(input bit want_rack, output bit got, output bit other_seen);
        got = 0; other_seen = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (want_rack ? dif.wack : dif.rack) other_seen = 1;
            if (want_rack ? dif.rack : dif.wack) got = 1;
        end
        if (!got) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_both(input logic [1:0] rl, input logic [31:0] ra, input logic [1:0] wl,
                           input logic [31:0] wa, input logic [31:0] wd, output logic [31:0] rv,
                           output bit wack_first, output bit wack_got);
        bit got, dummy;
        @(negedge clk);
        dif.re = 1; dif.rlen = rl; dif.raddr = ra;
        dif.we = 1; dif.wlen = wl; dif.waddr = wa; dif.wdata = wd;
        wait_sig(1, got, wack_first);
        rv = dif.rdata;
        dif.re = 0;
        wait_sig(0, wack_got, dummy);
        dif.we = 0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rv, a, wd;
    bit          ev, wf, wg;
    int          lat, extra;
    logic [1:0]  len;

    initial begin
        for (int i = 0; i < 16384; i++) mm[i] = 8'h00;
        dif.re = 0; dif.we = 0; dif.rlen = 0; dif.wlen = 0;
        dif.raddr = 0; dif.waddr = 0; dif.wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", dif.rdata, 32'h0);
        chk("reset_rack",  32'(dif.rack), 32'h0);
        chk("reset_wack",  32'(dif.wack), 32'h0);
        chk("reset_err",   32'(dif.err),  32'h0);
        chk("reset_busy",  32'(dif.busy), 32'h0);
        rst = 0;

        for (int i = 0; i < 64; i++) do_req(0, 2'b11, 32'(i * 4), 32'h0, rv, ev, lat);

        do_req(0, 2'b11, 32'h10, 32'hDEADBEEF, rv, ev, lat);
        chk("wack_latency", 32'(lat), 32'(L + 3));
        chk("wr_word_err", 32'(ev), 32'h0);
        do_req(1, 2'b11, 32'h10, 32'h0, rv, ev, lat);
        chk("rd_word", rv, 32'hDEADBEEF);
        chk("model_rd_word", m_rdata, 32'hDEADBEEF);
        chk("rack_latency", 32'(lat), 32'(L + 3));

        do_req(0, 2'b00, 32'h13, 32'h0000007F, rv, ev, lat);
        do_req(1, 2'b00, 32'h13, 32'h0, rv, ev, lat);
        chk("rd_byte", rv, 32'h0000007F);
        do_req(1, 2'b11, 32'h10, 32'h0, rv, ev, lat);
        chk("rd_word_merged", rv, 32'h7FADBEEF);
        chk("model_word_merged", m_rdata, 32'h7FADBEEF);

        do_req(1, 2'b01, 32'h11, 32'h0, rv, ev, lat);
        chk("half_misaligned_err", 32'(ev), 32'h1);
        chk("half_misaligned_rdata", rv, 32'h0);
        do_req(0, 2'b10, 32'h10, 32'h11111111, rv, ev, lat);
        chk("bad_len_err", 32'(ev), 32'h1);
        do_req(1, 2'b11, 32'h10, 32'h0, rv, ev, lat);
        chk("ram_unchanged", rv, 32'h7FADBEEF);
        do_req(1, 2'b11, 32'h0000_4010, 32'h0, rv, ev, lat);
        chk("oob_err", 32'(ev), 32'h1);

        do_both(2'b11, 32'h30, 2'b00, 32'h30, 32'h00000055, rv, wf, wg);
        chk("both_read_old", rv, 32'h0);
        chk("both_rack_first", 32'(wf), 32'h0);
        chk("both_wack_seen", 32'(wg), 32'h1);
        do_req(1, 2'b11, 32'h30, 32'h0, rv, ev, lat);
        chk("both_write_landed", rv, 32'h00000055);

        // Hold re after rack: no second acknowledge until it drops.
        @(negedge clk);
        dif.re = 1; dif.rlen = 2'b11; dif.raddr = 32'h10;
        wait_sig(1, wg, wf);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (dif.rack) extra++;
        end
        chk("hold_extra_rack", 32'(extra), 32'h0);
        chk("hold_not_busy", 32'(dif.busy), 32'h0);
        dif.re = 0;
        do_req(1, 2'b00, 32'h13, 32'h0, rv, ev, lat);
        chk("rearm_read", rv, 32'h0000007F);

        // Reset during WAIT of a write aborts it without touching RAM.
        do_req(0, 2'b11, 32'h20, 32'hCAFEF00D, rv, ev, lat);
        @(negedge clk);
        dif.we = 1; dif.wlen = 2'b11; dif.waddr = 32'h20; dif.wdata = 32'h12345678;
        repeat (2) @(negedge clk);
        rst = 1; dif.we = 0;
        #1;
        chk("rst_busy", 32'(dif.busy), 32'h0);
        chk("rst_wack", 32'(dif.wack), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_wack", 32'(dif.wack), 32'h0);
        end
        rst = 0;
        do_req(1, 2'b11, 32'h20, 32'h0, rv, ev, lat);
        chk("rst_old_value", rv, 32'hCAFEF00D);
        chk("model_rst_old_value", m_rdata, 32'hCAFEF00D);

        for (int k = 0; k < 200; k++) begin
            int r;
            r   = $urandom_range(0, 9);
            len = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            a   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (len == 2'b01) a = a & ~32'h1;
                if (len == 2'b11) a = a & ~32'h3;
            end
            if ($urandom_range(0, 15) == 0) a = a | (32'h4000 << $urandom_range(0, 17));
            wd = $urandom;
            if ($urandom_range(0, 9) == 0)
                do_both(len, a, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63) * 4), wd, rv, wf, wg);
            else
                do_req(1'($urandom_range(0, 1)), len, a, wd, rv, ev, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the data-access handshake driven by the memory-access pipeline stage. Accepts level-held read/write requests with byte/half/word length, performs the access to an internal byte-addressed RAM after a configurable wait latency, and answers with a one-cycle read or write acknowledge. Read data is returned zero-extended; sign extension is the requester's job.

## Interface
- MADDR_L, 32, request address width (byte address)
- DATA_L, 32, data width; fixed 4 byte lanes
- DEPTH_LOG2, 12, log2 of RAM size in 32-bit words
- LATENCY, 2, wait cycles inserted before the RAM access (0 allowed)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- re  in  1  read request, held high until rack seen
- we  in  1  write request, held high until wack seen
- rlen  in  2  read length: 00 byte, 01 half, 11 word, 10 illegal
- wlen  in  2  write length, same encoding
- raddr  in  MADDR_L  read byte address
- waddr  in  MADDR_L  write byte address
- wdata  in  DATA_L  write data, right-aligned (byte in [7:0], half in [15:0])
- rdata  out  DATA_L  read data, zero-extended, right-aligned
- rack  out  1  read acknowledge, one-cycle pulse
- wack  out  1  write acknowledge, one-cycle pulse
- err  out  1  pulses with rack/wack when the request was rejected
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, ACCESS, ACK.
- IDLE: sample re/we each edge; a port is eligible only if armed. Read wins if both eligible; the write stays pending and is taken on a later IDLE edge.
- Accept: latch op, address, length, wdata; clear that port's armed flag; load cnt=LATENCY; go WAIT.
- WAIT: cnt==0 -> ACCESS, else cnt--.
- ACCESS: check request; if legal, issue RAM read or commit RAM write with byte enables; go ACK.
- ACK: drive rack or wack (per op) high for exactly this cycle; read result registered into rdata on entry; go IDLE.
- Armed flag per port: set at reset and on any edge where the request input is low. Prevents re-serving a request the requester has not yet dropped.
- Little-endian lanes: lane = addr[1:0]; byte enable 0001<<lane, half 0011<<lane, word 1111.
- Reject (err=1 with ack, no RAM write, rdata=0): len==10; half with addr[0]=1; word with addr[1:0]!=00; any address bit at or above DEPTH_LOG2+2 set.
- Read result: selected lanes shifted down to bit 0, upper bits zero.

## Timing
- Reset values: rdata=0, rack=0, wack=0, err=0, busy=0, state IDLE, both ports armed. RAM contents are not reset.
- Request seen at edge E0 -> ack and err high in the cycle after edge E0+LATENCY+2, i.e. ack rises at edge E0+LATENCY+2, falls at E0+LATENCY+3. With LATENCY=0: ack at E0+2.
- rdata valid from the rack edge and stable until the next read ack; writes do not disturb it.
- RAM write becomes visible to a read accepted at or after the write's ACK cycle.
- Input changes after E0 are ignored for the current operation.
- Back-to-back: earliest next accept is the edge after ACK, provided the port is armed.
- rst mid-operation: everything aborts immediately, no ack. A write reset before its ACCESS edge leaves RAM unchanged.

## Structure
- Shared package mem_defs: length encodings LEN_B=2'b00, LEN_H=2'b01, LEN_W=2'b11; state encoding; byte-enable helper function.
- One sub-module, byte_ram: DEPTH words × 4 byte lanes, synchronous write with 4-bit byte enable, synchronous 1-cycle read, no reset.
- The top level holds the FSM, wait counter, armed flags, legality check, and lane shift.

## Test plan
- LATENCY=2, write word 0xDEADBEEF to 0x10, then read word at 0x10 -> wack at E0+4; later rdata=0xDEADBEEF with rack, err=0.
- Byte write 0x7F to 0x13, then read byte at 0x13 and word at 0x10 -> 0x0000007F; 0x7FADBEEF.
- Half read at 0x11 and word write with wlen=10 -> err=1 with ack, rdata=0, RAM unchanged.
- re and we asserted together at the same edge -> rack served first; wack follows, no lost request.
- re held high for 5 cycles after rack -> exactly one rack, no second access until re dropped and reasserted.
- rst asserted during WAIT of a write of 0x12345678 to 0x20 -> no wack; a later read of 0x20 returns the old value.
